// File: rtl/conv_enc_pkg.sv
// Shared definitions for the rate-1/2, K=3 (7/5 octal) convolutional encoder
// and its frame sequencer: code constants, FSM state type and the trellis step.
package conv_enc_pkg;

   localparam int         K  = 3;
   localparam logic [2:0] G0 = 3'b111;
   localparam logic [2:0] G1 = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ENCODE = 2'd1,
      TAIL   = 2'd2,
      DONE   = 2'd3
   } fsm_state_t;

   typedef struct packed {
      logic [1:0] sym;   // {g0, g1}
      logic [1:0] next;  // next trellis state {s1, s0}
   } enc_step_t;

   // One trellis step: taps are {u, s1, s0}, masked by each generator and reduced.
   function automatic enc_step_t enc_step(input logic [1:0] state, input logic u);
      logic [2:0] taps;
      enc_step_t  res;
      taps     = {u, state};
      res.sym  = {^(taps & G0), ^(taps & G1)};
      res.next = {u, state[1]};
      return res;
   endfunction

endpackage

// File: rtl/conv_enc_k3.sv
// Two-bit trellis register of the K=3 encoder. The symbol for the current
// input is combinational; the state advances only when en is high.
module conv_enc_k3
   import conv_enc_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic       u,
   output logic [1:0] sym,
   output logic [1:0] state
);

   logic [1:0] state_r;
   enc_step_t  step_s;

   // Evaluate the trellis step for the present state and input bit.
   always_comb begin
      step_s = enc_step(state_r, u);
   end

   // Trellis state register: clear wins over advance, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= 2'b00;
      end else if (clr) begin
         state_r <= 2'b00;
      end else if (en) begin
         state_r <= step_s.next;
      end else begin
         state_r <= state_r;
      end
   end

   assign sym   = step_s.sym;
   assign state = state_r;

endmodule

// File: rtl/conv_enc_frame_ctrl.sv
// Frame sequencer: latches a parallel frame, feeds it bit by bit (bit 0 first)
// through the K=3 encoder under a valid/ready handshake, appends the zero tail
// that returns the trellis to 00, and collects the packed code word.
module conv_enc_frame_ctrl
   import conv_enc_pkg::*;
#(
   parameter  int FRAME_LEN = 6,
   localparam int TAIL_LEN  = K - 1,
   localparam int OUT_W     = 2 * (FRAME_LEN + TAIL_LEN)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [FRAME_LEN-1:0] frame_in,
   output logic                 busy,
   output logic                 sym_valid,
   input  logic                 sym_ready,
   output logic [1:0]           sym_data,
   output logic                 done,
   output logic [OUT_W-1:0]     code_word
);

   localparam int CNT_W = $clog2(FRAME_LEN + TAIL_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_INFO = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] LAST_TAIL = CNT_W'(FRAME_LEN + TAIL_LEN - 1);

   fsm_state_t           state_r;
   fsm_state_t           next_s;
   logic [FRAME_LEN-1:0] frame_r;
   logic [CNT_W-1:0]     bit_cnt_r;
   logic [OUT_W-1:0]     code_word_r;
   logic                 accept_s;
   logic                 hs_s;
   logic                 u_s;
   logic [1:0]           sym_s;
   logic [1:0]           enc_state_s;

   assign accept_s  = (state_r == IDLE) && start;
   assign sym_valid = (state_r == ENCODE) || (state_r == TAIL);
   assign hs_s      = sym_valid && sym_ready;
   assign busy      = (state_r != IDLE);
   assign done      = (state_r == DONE);
   assign code_word = code_word_r;
   // Symbol depends only on registered state; sym_ready never reaches it.
   assign sym_data  = sym_valid ? sym_s : 2'b00;

   // Select the information bit under bit_cnt; tail and idle feed zeros.
   always_comb begin
      u_s = 1'b0;
      if (state_r == ENCODE) begin
         for (int i = 0; i < FRAME_LEN; i++) begin
            u_s = u_s | (frame_r[i] & (bit_cnt_r == CNT_W'(i)));
         end
      end else begin
         u_s = 1'b0;
      end
   end

   conv_enc_k3 u_enc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept_s),
      .en    (hs_s),
      .u     (u_s),
      .sym   (sym_s),
      .state (enc_state_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state logic: leave each phase on the handshake of its last bit.
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) next_s = ENCODE;
            else       next_s = IDLE;
         end
         ENCODE: begin
            if (hs_s && (bit_cnt_r == LAST_INFO)) next_s = TAIL;
            else                                  next_s = ENCODE;
         end
         TAIL: begin
            if (hs_s && (bit_cnt_r == LAST_TAIL)) next_s = DONE;
            else                                  next_s = TAIL;
         end
         DONE:    next_s = IDLE;
         default: next_s = IDLE;
      endcase
   end

   // Frame latch, bit counter and code-word shifter; all hold under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_r     <= '0;
         bit_cnt_r   <= '0;
         code_word_r <= '0;
      end else if (accept_s) begin
         frame_r     <= frame_in;
         bit_cnt_r   <= '0;
         code_word_r <= '0;
      end else if (hs_s) begin
         frame_r     <= frame_r;
         bit_cnt_r   <= bit_cnt_r + CNT_W'(1);
         code_word_r <= {code_word_r[OUT_W-3:0], sym_s};
      end else begin
         frame_r     <= frame_r;
         bit_cnt_r   <= bit_cnt_r;
         code_word_r <= code_word_r;
      end
   end

endmodule
